// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Purpose:
//   Runs one complete frame through the convolution datapath. A start request
//   streams the N*N image out of the image block RAM into conv_top, with the
//   pixel valid delayed to match the RAM read latency. conv_top is kept
//   enabled until it reports that its run has finished. Every valid conv_top
//   result is written to the result store at sequential addresses, and done
//   pulses once the frame is complete.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst             asynchronous active-low reset
//   start_i         frame start request, sampled only while idle
//   busy_o          high whenever a frame is in progress
//   done_o          one-cycle pulse at frame completion
//   err_o           sticky run timeout flag, cleared by the next accepted start
//   bram_en_o       image RAM read enable
//   bram_addr_o     image RAM read address
//   bram_data_i     image RAM read data (RD_LAT cycles after the address)
//   conv_ena_o      conv_top enable
//   conv_data_o     pixel to conv_top
//   conv_valid_o    pixel valid to conv_top
//   conv_data_i     conv_top result
//   conv_valid_i    conv_top result valid
//   conv_running_i  conv_top busy indicator
//   res_we_o        result store write enable
//   res_addr_o      result store write address
//   res_data_o      result store write data
//   res_count_o     results written in the current or last frame
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
   parameter int N          = 100,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int RD_LAT     = 1,
   parameter int TIMEOUT    = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  bram_en_o,
   output logic [ADDR_WIDTH-1:0] bram_addr_o,
   input  logic [DATA_WIDTH-1:0] bram_data_i,
   output logic                  conv_ena_o,
   output logic [DATA_WIDTH-1:0] conv_data_o,
   output logic                  conv_valid_o,
   input  logic [DATA_WIDTH-1:0] conv_data_i,
   input  logic                  conv_valid_i,
   input  logic                  conv_running_i,
   output logic                  res_we_o,
   output logic [ADDR_WIDTH-1:0] res_addr_o,
   output logic [DATA_WIDTH-1:0] res_data_o,
   output logic [ADDR_WIDTH-1:0] res_count_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N * N - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
   localparam int                    WAIT_W     = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
   localparam logic [1:0]            DRAIN_LAST = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      WAIT_RUN,
      FINISH
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [1:0]              drain_cnt_reg;
   logic [WAIT_W-1:0]       wait_cnt_reg;
   logic                    seen_run_reg;
   logic                    err_reg;
   logic                    timeout_hit;
   logic                    start_accept;

   // Issue-flag delay line: bit k is the flag delayed by k+1 cycles.
   logic [RD_LAT-1:0]       valid_pipe_reg;
   logic [RD_LAT:0]         valid_pipe_in;
   logic                    issue;

   logic                    res_we_reg;
   logic [ADDR_WIDTH-1:0]   res_addr_out_reg;
   logic [DATA_WIDTH-1:0]   res_data_reg;
   logic [ADDR_WIDTH-1:0]   res_ptr_reg;
   logic [ADDR_WIDTH-1:0]   res_count_reg;
   logic                    capture;

   // -------------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      timeout_hit = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      bram_en_o   = 1'b0;
      conv_ena_o  = 1'b0;
      case (state_reg)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            bram_en_o  = 1'b1;
            conv_ena_o = 1'b1;
            if (addr_reg == LAST_ADDR) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            conv_ena_o = 1'b1;
            // The last issued read surfaces in the final DRAIN cycle.
            if (drain_cnt_reg == DRAIN_LAST) begin
               state_next = WAIT_RUN;
            end
         end
         WAIT_RUN: begin
            conv_ena_o = 1'b1;
            if (seen_run_reg && !conv_running_i) begin
               state_next = FINISH;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = FINISH;
            end
         end
         FINISH: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy_o     = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign start_accept = (state_reg == IDLE) && start_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Read address, drain/wait counters, run tracking and error flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg      <= '0;
         drain_cnt_reg <= '0;
         wait_cnt_reg  <= '0;
         seen_run_reg  <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         if (start_accept) begin
            addr_reg     <= '0;
            seen_run_reg <= 1'b0;
            err_reg      <= 1'b0;
         end else begin
            // Address holds at the last pixel once the fetch is complete.
            if (state_reg == FETCH && addr_reg != LAST_ADDR) begin
               addr_reg <= addr_reg + ADDR_WIDTH'(1);
            end
            // Running may already be seen while pixels are still streaming.
            if (busy_o && conv_running_i) begin
               seen_run_reg <= 1'b1;
            end
            if (timeout_hit) begin
               err_reg <= 1'b1;
            end
         end

         if (state_reg == DRAIN) begin
            drain_cnt_reg <= drain_cnt_reg + 2'd1;
         end else begin
            drain_cnt_reg <= '0;
         end

         if (state_reg == WAIT_RUN) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         end else begin
            wait_cnt_reg <= '0;
         end
      end
   end

   assign bram_addr_o = addr_reg;
   assign err_o       = err_reg;

   // -------------------------------------------------------------------------
   // Pixel valid alignment to the RAM read latency
   // -------------------------------------------------------------------------
   assign issue         = (state_reg == FETCH);
   assign valid_pipe_in = {valid_pipe_reg, issue};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_pipe_reg <= '0;
      end else begin
         valid_pipe_reg <= valid_pipe_in[RD_LAT-1:0];
      end
   end

   assign conv_valid_o = valid_pipe_reg[RD_LAT-1];
   // Data passes straight through but is held at zero outside valid cycles,
   // so nothing stale reaches conv_top while idle or in reset.
   assign conv_data_o  = conv_valid_o ? bram_data_i : '0;

   // -------------------------------------------------------------------------
   // Result capture: one registered write per running & valid result
   // -------------------------------------------------------------------------
   assign capture = busy_o && conv_running_i && conv_valid_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_we_reg       <= 1'b0;
         res_addr_out_reg <= '0;
         res_data_reg     <= '0;
         res_ptr_reg      <= '0;
         res_count_reg    <= '0;
      end else begin
         res_we_reg <= 1'b0;
         if (start_accept) begin
            res_addr_out_reg <= '0;
            res_ptr_reg      <= '0;
            res_count_reg    <= '0;
         end else if (capture) begin
            res_we_reg       <= 1'b1;
            res_data_reg     <= conv_data_i;
            res_addr_out_reg <= res_ptr_reg;
            // Saturate instead of wrapping so earlier results are never
            // overwritten; overflow writes pile up at the top address.
            if (res_ptr_reg != ADDR_MAX) begin
               res_ptr_reg <= res_ptr_reg + ADDR_WIDTH'(1);
            end
            if (res_count_reg != ADDR_MAX) begin
               res_count_reg <= res_count_reg + ADDR_WIDTH'(1);
            end
         end
      end
   end

   assign res_we_o    = res_we_reg;
   assign res_addr_o  = res_addr_out_reg;
   assign res_data_o  = res_data_reg;
   assign res_count_o = res_count_reg;

endmodule
